// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline sequencing controller.
//   state_t     : controller states (RUN, STALL, DRAIN, HALTED)
//   FWD_*       : EX-stage ALU operand select encodings
//   HALT_INSTR  : the all-ones instruction word that requests a halt
//   regMatch    : "this writer produces the register this reader needs"
//   isHaltInstr : compares a fetched word against HALT_INSTR
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   // Register $zero is hardwired, so a write to it never produces a
   // dependency, even when RegWrite is set.
   function automatic logic regMatch(input logic       wrEn,
                                     input logic [4:0] wrReg,
                                     input logic [4:0] srcReg);
      return wrEn && (wrReg != 5'd0) && (wrReg == srcReg);
   endfunction

   function automatic logic isHaltInstr(input logic [31:0] instr);
      return instr == HALT_INSTR;
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Purely combinational EX-stage forwarding select generation.
// Ports:
//   i_exRs, i_exRt         source registers of the instruction in ID/EX
//   i_memRegWrite/WrReg    EX/MEM writer
//   i_wbRegWrite/WrReg     MEM/WB writer
//   o_fwdA, o_fwdB         ALU operand selects (FWD_RF / FWD_MEM / FWD_WB)
// ---------------------------------------------------------------------------
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] i_exRs,
   input  logic [4:0] i_exRt,
   input  logic       i_memRegWrite,
   input  logic [4:0] i_memWrReg,
   input  logic       i_wbRegWrite,
   input  logic [4:0] i_wbWrReg,
   output logic [1:0] o_fwdA,
   output logic [1:0] o_fwdB
);

   // EX/MEM holds the younger result, so it is checked first and wins
   // whenever both later stages write the same register.
   always_comb begin
      o_fwdA = FWD_RF;
      if (regMatch(i_memRegWrite, i_memWrReg, i_exRs)) begin
         o_fwdA = FWD_MEM;
      end else if (regMatch(i_wbRegWrite, i_wbWrReg, i_exRs)) begin
         o_fwdA = FWD_WB;
      end
   end

   // Operand B follows exactly the same priority using rt.
   always_comb begin
      o_fwdB = FWD_RF;
      if (regMatch(i_memRegWrite, i_memWrReg, i_exRt)) begin
         o_fwdB = FWD_MEM;
      end else if (regMatch(i_wbRegWrite, i_wbWrReg, i_exRt)) begin
         o_fwdB = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage MIPS datapath.
//   - load-use hazard detection with LOAD_LAT bubble cycles per hazard
//   - wrong-path squash on a taken branch resolved in EX
//   - EX-stage forwarding selects (via fwd_unit)
//   - orderly halt: freeze fetch, drain DRAIN_CYCLES cycles, report halted
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   id_rs, id_rt                 sources of the instruction in IF/ID
//   ex_rs, ex_rt                 sources of the instruction in ID/EX
//   ex_memread, ex_wr_reg        ID/EX load flag and destination
//   mem_regwrite, mem_wr_reg     EX/MEM writer
//   wb_regwrite, wb_wr_reg       MEM/WB writer
//   ex_branch_taken              branch in EX resolved taken
//   halt_req                     fetched word is the halt instruction
//   pc_write, if_id_write        PC / IF/ID load enables
//   if_id_flush, id_ex_bubble    IF/ID loads NOP / ID/EX loads zero control
//   fwd_a, fwd_b                 ALU operand selects
//   halted                       pipeline drained and frozen
//   stall_count                  saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LOAD_LAT     = 1,
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 16
)(
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_wr_reg,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_wr_reg,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_wr_reg,
   input  logic             ex_branch_taken,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   // The first bubble is issued from RUN, so the stall counter only has
   // to cover the remaining LOAD_LAT-1 cycles; the same holds for the
   // drain counter, whose first frozen cycle is the halt_req cycle itself.
   localparam logic [2:0]       STALL_LOAD = 3'(LOAD_LAT - 1);
   localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [2:0]       r_stallCnt;
   logic [3:0]       r_drainCnt;
   logic [CNT_W-1:0] r_stallCount;

   state_t           w_nextState;
   logic [2:0]       w_nextStallCnt;
   logic [3:0]       w_nextDrainCnt;
   logic             w_countStall;
   logic             w_loadUse;
   logic             w_cntSat;

   // A load in EX whose destination feeds the instruction in ID cannot be
   // forwarded in time; the consumer must wait in ID.
   assign w_loadUse = ex_memread && (ex_wr_reg != 5'd0) &&
                      ((ex_wr_reg == id_rs) || (ex_wr_reg == id_rt));

   assign w_cntSat    = &r_stallCount;
   assign stall_count = r_stallCount;

   // Forwarding is independent of the sequencing state.
   fwd_unit u_fwdUnit (
      .i_exRs        (ex_rs),
      .i_exRt        (ex_rt),
      .i_memRegWrite (mem_regwrite),
      .i_memWrReg    (mem_wr_reg),
      .i_wbRegWrite  (wb_regwrite),
      .i_wbWrReg     (wb_wr_reg),
      .o_fwdA        (fwd_a),
      .o_fwdB        (fwd_b)
   );

   // State, counters and the statistics counter. Reset returns everything
   // to a running pipeline with no history.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= RUN;
         r_stallCnt   <= 3'd0;
         r_drainCnt   <= 4'd0;
         r_stallCount <= '0;
      end else begin
         r_state    <= w_nextState;
         r_stallCnt <= w_nextStallCnt;
         r_drainCnt <= w_nextDrainCnt;
         if (w_countStall && !w_cntSat) begin
            r_stallCount <= r_stallCount + CNT_ONE;
         end
      end
   end

   // Next-state and zero-latency control outputs. A taken branch always
   // wins (except once halted): whatever is behind it in IF and ID is
   // wrong-path work, including a pending stall or a halt that was fetched
   // speculatively. On a branch the PC stays enabled so it can take the
   // target.
   always_comb begin
      w_nextState    = r_state;
      w_nextStallCnt = r_stallCnt;
      w_nextDrainCnt = r_drainCnt;
      w_countStall   = 1'b0;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      halted         = 1'b0;

      case (r_state)
         RUN: begin
            if (ex_branch_taken) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (halt_req) begin
               pc_write       = 1'b0;
               if_id_flush    = 1'b1;
               w_nextDrainCnt = DRAIN_LOAD;
               w_nextState    = DRAIN;
            end else if (w_loadUse) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               w_countStall = 1'b1;
               if (LOAD_LAT > 1) begin
                  w_nextStallCnt = STALL_LOAD;
                  w_nextState    = STALL;
               end
            end
         end

         STALL: begin
            if (ex_branch_taken) begin
               if_id_flush    = 1'b1;
               id_ex_bubble   = 1'b1;
               w_nextStallCnt = 3'd0;
               w_nextState    = RUN;
            end else begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               w_countStall = 1'b1;
               if (r_stallCnt <= 3'd1) begin
                  w_nextStallCnt = 3'd0;
                  w_nextState    = RUN;
               end else begin
                  w_nextStallCnt = r_stallCnt - 3'd1;
               end
            end
         end

         // Older instructions keep flowing through ID/EX..WB; only new
         // fetches are suppressed.
         DRAIN: begin
            if (ex_branch_taken) begin
               if_id_flush    = 1'b1;
               id_ex_bubble   = 1'b1;
               w_nextDrainCnt = 4'd0;
               w_nextState    = RUN;
            end else begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               if (r_drainCnt <= 4'd1) begin
                  w_nextDrainCnt = 4'd0;
                  w_nextState    = HALTED;
               end else begin
                  w_nextDrainCnt = r_drainCnt - 4'd1;
               end
            end
         end

         HALTED: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            halted       = 1'b1;
         end

         default: begin
            w_nextState = RUN;
         end
      endcase

      // While reset is held the pipeline is presented as freshly running.
      if (reset) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
         halted       = 1'b0;
         w_countStall = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Self-checking bench for hazard_stall_ctrl. Three instances share one
// stimulus stream: LOAD_LAT=1, LOAD_LAT=3, and a 2-bit stall counter for
// saturation. Expected outputs are queued as each vector is driven and
// compared by a monitor shortly after the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   // Packed control view: {pc_write, if_id_write, if_id_flush, id_ex_bubble, halted}
   localparam logic [4:0] C_RUN = 5'b11000;
   localparam logic [4:0] C_BR  = 5'b11110;
   localparam logic [4:0] C_STL = 5'b00010;
   localparam logic [4:0] C_DRN = 5'b01100;
   localparam logic [4:0] C_HLT = 5'b00111;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
   logic       ex_memread, mem_regwrite, wb_regwrite, ex_branch_taken, halt_req;

   logic        d1_pc_write, d1_if_id_write, d1_if_id_flush, d1_id_ex_bubble, d1_halted;
   logic [1:0]  d1_fwd_a, d1_fwd_b;
   logic [15:0] d1_stall_count;
   logic        d3_pc_write, d3_if_id_write, d3_if_id_flush, d3_id_ex_bubble, d3_halted;
   logic [1:0]  d3_fwd_a, d3_fwd_b;
   logic [15:0] d3_stall_count;
   logic        ds_pc_write, ds_if_id_write, ds_if_id_flush, ds_id_ex_bubble, ds_halted;
   logic [1:0]  ds_fwd_a, ds_fwd_b;
   logic [1:0]  ds_stall_count;

   typedef struct {
      int          sel;
      logic [4:0]  ctl;
      logic [3:0]  fwd;
      logic [15:0] cnt;
      string       tag;
   } expT;

   expT sbq[$];
   int  checkCount = 0;
   int  failCount  = 0;

   always #5 clock = ~clock;

   hazard_stall_ctrl #(.LOAD_LAT(1), .DRAIN_CYCLES(4), .CNT_W(16)) u_dut1 (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_wr_reg(ex_wr_reg),
      .mem_regwrite(mem_regwrite), .mem_wr_reg(mem_wr_reg),
      .wb_regwrite(wb_regwrite), .wb_wr_reg(wb_wr_reg),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
      .pc_write(d1_pc_write), .if_id_write(d1_if_id_write), .if_id_flush(d1_if_id_flush),
      .id_ex_bubble(d1_id_ex_bubble), .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b),
      .halted(d1_halted), .stall_count(d1_stall_count));

   hazard_stall_ctrl #(.LOAD_LAT(3), .DRAIN_CYCLES(4), .CNT_W(16)) u_dut3 (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_wr_reg(ex_wr_reg),
      .mem_regwrite(mem_regwrite), .mem_wr_reg(mem_wr_reg),
      .wb_regwrite(wb_regwrite), .wb_wr_reg(wb_wr_reg),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
      .pc_write(d3_pc_write), .if_id_write(d3_if_id_write), .if_id_flush(d3_if_id_flush),
      .id_ex_bubble(d3_id_ex_bubble), .fwd_a(d3_fwd_a), .fwd_b(d3_fwd_b),
      .halted(d3_halted), .stall_count(d3_stall_count));

   hazard_stall_ctrl #(.LOAD_LAT(1), .DRAIN_CYCLES(4), .CNT_W(2)) u_dutSat (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_wr_reg(ex_wr_reg),
      .mem_regwrite(mem_regwrite), .mem_wr_reg(mem_wr_reg),
      .wb_regwrite(wb_regwrite), .wb_wr_reg(wb_wr_reg),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
      .pc_write(ds_pc_write), .if_id_write(ds_if_id_write), .if_id_flush(ds_if_id_flush),
      .id_ex_bubble(ds_id_ex_bubble), .fwd_a(ds_fwd_a), .fwd_b(ds_fwd_b),
      .halted(ds_halted), .stall_count(ds_stall_count));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Queues the expected response of one instance for the vector just driven.
   task automatic applyStimulus(input string tag, input int sel, input logic [4:0] ctl,
                                input logic [3:0] fwd, input logic [15:0] cnt);
      expT e;
      e.sel = sel;
      e.ctl = ctl;
      e.fwd = fwd;
      e.cnt = cnt;
      e.tag = tag;
      sbq.push_back(e);
   endtask

   task automatic idle();
      reset = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
      ex_memread = 1'b0; ex_wr_reg = 5'd0;
      mem_regwrite = 1'b0; mem_wr_reg = 5'd0;
      wb_regwrite = 1'b0; wb_wr_reg = 5'd0;
      ex_branch_taken = 1'b0; halt_req = 1'b0;
   endtask

   task automatic nextVec();
      @(negedge clock);
      idle();
   endtask

   task automatic doReset();
      nextVec();
      reset = 1'b1;
   endtask

   task automatic hazard();
      ex_memread = 1'b1;
      ex_wr_reg  = 5'd8;
      id_rs      = 5'd8;
   endtask

   // Compares all queued expectations once combinational outputs settle.
   always @(negedge clock) begin : monitor
      expT         e;
      logic [4:0]  oc;
      logic [3:0]  of;
      logic [15:0] on;
      #2;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.sel)
            1: begin
               oc = {d1_pc_write, d1_if_id_write, d1_if_id_flush, d1_id_ex_bubble, d1_halted};
               of = {d1_fwd_a, d1_fwd_b};
               on = d1_stall_count;
            end
            3: begin
               oc = {d3_pc_write, d3_if_id_write, d3_if_id_flush, d3_id_ex_bubble, d3_halted};
               of = {d3_fwd_a, d3_fwd_b};
               on = d3_stall_count;
            end
            default: begin
               oc = {ds_pc_write, ds_if_id_write, ds_if_id_flush, ds_id_ex_bubble, ds_halted};
               of = {ds_fwd_a, ds_fwd_b};
               on = {14'd0, ds_stall_count};
            end
         endcase
         checkOutput({e.tag, ".ctl"}, {11'd0, oc}, {11'd0, e.ctl});
         checkOutput({e.tag, ".fwd"}, {12'd0, of}, {12'd0, e.fwd});
         checkOutput({e.tag, ".cnt"}, on, e.cnt);
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin : stimulus
      idle();
      reset = 1'b1;
      @(posedge clock);
      doReset();

      // Reset state on all instances
      nextVec();
      applyStimulus("rst_d1", 1, C_RUN, 4'b0000, 16'd0);
      applyStimulus("rst_d3", 3, C_RUN, 4'b0000, 16'd0);
      applyStimulus("rst_sat", 2, C_RUN, 4'b0000, 16'd0);

      // Load-use on rs: one bubble for LOAD_LAT=1, three for LOAD_LAT=3
      nextVec(); hazard();
      applyStimulus("lu1_c0", 1, C_STL, 4'b0000, 16'd0);
      applyStimulus("lu3_c0", 3, C_STL, 4'b0000, 16'd0);
      nextVec();
      applyStimulus("lu1_c1", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("lu3_c1", 3, C_STL, 4'b0000, 16'd1);
      nextVec();
      applyStimulus("lu1_c2", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("lu3_c2", 3, C_STL, 4'b0000, 16'd2);
      nextVec();
      applyStimulus("lu1_c3", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("lu3_c3", 3, C_RUN, 4'b0000, 16'd3);

      // Load to $zero and a non-load never stall
      nextVec(); ex_memread = 1'b1;
      applyStimulus("lu_r0_d1", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("lu_r0_d3", 3, C_RUN, 4'b0000, 16'd3);
      nextVec(); ex_wr_reg = 5'd8; id_rs = 5'd8;
      applyStimulus("lu_nord", 1, C_RUN, 4'b0000, 16'd1);

      // Load-use through rt
      nextVec(); ex_memread = 1'b1; ex_wr_reg = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
      applyStimulus("lu_rt_c0", 1, C_STL, 4'b0000, 16'd1);
      nextVec();
      applyStimulus("lu_rt_c1", 1, C_RUN, 4'b0000, 16'd2);

      // Branch cutting a LOAD_LAT=3 stall short on its third bubble cycle
      doReset();
      nextVec(); hazard();
      applyStimulus("bst_d1_c0", 1, C_STL, 4'b0000, 16'd0);
      applyStimulus("bst_d3_c0", 3, C_STL, 4'b0000, 16'd0);
      nextVec();
      applyStimulus("bst_d1_c1", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("bst_d3_c1", 3, C_STL, 4'b0000, 16'd1);
      nextVec(); ex_branch_taken = 1'b1;
      applyStimulus("bst_d1_br", 1, C_BR, 4'b0000, 16'd1);
      applyStimulus("bst_d3_br", 3, C_BR, 4'b0000, 16'd2);
      nextVec();
      applyStimulus("bst_d1_run", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("bst_d3_run", 3, C_RUN, 4'b0000, 16'd2);
      nextVec();
      applyStimulus("bst_d3_run2", 3, C_RUN, 4'b0000, 16'd2);

      // Branch outranks a simultaneous load-use hazard
      nextVec(); hazard(); ex_branch_taken = 1'b1;
      applyStimulus("brhz_d1", 1, C_BR, 4'b0000, 16'd1);
      applyStimulus("brhz_d3", 3, C_BR, 4'b0000, 16'd2);
      nextVec();
      applyStimulus("brhz_d1_n", 1, C_RUN, 4'b0000, 16'd1);
      applyStimulus("brhz_d3_n", 3, C_RUN, 4'b0000, 16'd2);

      // Forwarding selects {fwd_a, fwd_b}
      nextVec(); mem_regwrite = 1'b1; mem_wr_reg = 5'd5; wb_regwrite = 1'b1;
      wb_wr_reg = 5'd5; ex_rs = 5'd5;
      applyStimulus("fwd_mem_wins", 1, C_RUN, 4'b1000, 16'd1);
      nextVec(); wb_regwrite = 1'b1; wb_wr_reg = 5'd5; mem_wr_reg = 5'd5; ex_rs = 5'd5;
      applyStimulus("fwd_wb", 1, C_RUN, 4'b0100, 16'd1);
      nextVec(); ex_rs = 5'd3; ex_rt = 5'd0; wb_regwrite = 1'b1; wb_wr_reg = 5'd0;
      applyStimulus("fwd_zero_b", 1, C_RUN, 4'b0000, 16'd1);
      nextVec(); ex_rs = 5'd7; ex_rt = 5'd7; mem_regwrite = 1'b1; mem_wr_reg = 5'd7;
      wb_regwrite = 1'b1; wb_wr_reg = 5'd7;
      applyStimulus("fwd_both_mem", 1, C_RUN, 4'b1010, 16'd1);
      nextVec(); ex_rs = 5'd6; ex_rt = 5'd4; mem_regwrite = 1'b1; mem_wr_reg = 5'd4;
      wb_regwrite = 1'b1; wb_wr_reg = 5'd6;
      applyStimulus("fwd_split", 1, C_RUN, 4'b0110, 16'd1);
      nextVec(); ex_rs = 5'd0; mem_regwrite = 1'b1; mem_wr_reg = 5'd0;
      applyStimulus("fwd_zero_a", 1, C_RUN, 4'b0000, 16'd1);

      // Back-to-back hazards saturate a 2-bit counter at 3
      doReset();
      for (int i = 0; i < 5; i++) begin
         nextVec(); hazard();
         applyStimulus("sat_hz", 2, C_STL, 4'b0000, (i < 3) ? 16'(i) : 16'd3);
      end
      nextVec();
      applyStimulus("sat_end", 2, C_RUN, 4'b0000, 16'd3);
      applyStimulus("sat_d1", 1, C_RUN, 4'b0000, 16'd5);

      // Reset in the middle of a drain
      nextVec(); halt_req = 1'b1;
      applyStimulus("rdrn_req", 1, C_DRN, 4'b0000, 16'd5);
      nextVec();
      applyStimulus("rdrn_d1", 1, C_DRN, 4'b0000, 16'd5);
      doReset();
      nextVec();
      applyStimulus("rdrn_after", 1, C_RUN, 4'b0000, 16'd0);
      applyStimulus("rdrn_after3", 3, C_RUN, 4'b0000, 16'd0);

      // Full halt: halted exactly four cycles after the request, then sticky
      nextVec(); halt_req = 1'b1;
      applyStimulus("hlt_req", 1, C_DRN, 4'b0000, 16'd0);
      applyStimulus("hlt_req3", 3, C_DRN, 4'b0000, 16'd0);
      for (int i = 1; i < 4; i++) begin
         nextVec();
         applyStimulus("hlt_drain", 1, C_DRN, 4'b0000, 16'd0);
      end
      nextVec();
      applyStimulus("hlt_on", 1, C_HLT, 4'b0000, 16'd0);
      applyStimulus("hlt_on3", 3, C_HLT, 4'b0000, 16'd0);
      for (int i = 0; i < 20; i++) begin
         nextVec(); halt_req = i[0];
         applyStimulus("hlt_hold", 1, C_HLT, 4'b0000, 16'd0);
      end

      // Branch on the second drain cycle cancels the halt
      doReset();
      nextVec(); halt_req = 1'b1;
      applyStimulus("bdrn_req", 1, C_DRN, 4'b0000, 16'd0);
      nextVec(); halt_req = 1'b1;
      applyStimulus("bdrn_d1", 1, C_DRN, 4'b0000, 16'd0);
      nextVec(); ex_branch_taken = 1'b1;
      applyStimulus("bdrn_br", 1, C_BR, 4'b0000, 16'd0);
      for (int i = 0; i < 6; i++) begin
         nextVec();
         applyStimulus("bdrn_run", 1, C_RUN, 4'b0000, 16'd0);
      end

      @(negedge clock);
      #4;
      $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
      $finish;
   end

endmodule
